// File: rtl/sweep_ctrl_if.sv
// Control/config bundle between the sweep sequencer and its driver, plus the sinegen-facing outputs.
interface sweep_ctrl_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DWELL_W = 16
) ();
    logic               start;
    logic               abort;
    logic               repeat_mode;
    logic [WIDTH-1:0]   start_incr;
    logic [WIDTH-1:0]   stop_incr;
    logic [WIDTH-1:0]   step;
    logic [DWELL_W-1:0] dwell;
    logic               en;
    logic [WIDTH-1:0]   incr;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, repeat_mode, start_incr, stop_incr, step, dwell,
        input  en, incr, busy, done
    );

    modport slave (
        input  start, abort, repeat_mode, start_incr, stop_incr, step, dwell,
        output en, incr, busy, done
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Linear chirp sequencer: steps the sinegen phase increment from start to stop,
// holding each value for a dwell period, single-shot or repeating.
module sweep_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DWELL_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    sweep_ctrl_if.slave sif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [WIDTH-1:0]   incr_q, incr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   start_l_q, start_l_d;
    logic [WIDTH-1:0]   stop_l_q, stop_l_d;
    logic [WIDTH-1:0]   step_l_q, step_l_d;
    logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
    logic               repeat_l_q, repeat_l_d;

    logic               dir_up;
    logic               dwell_end;
    logic [WIDTH:0]     sum_up;
    logic [WIDTH-1:0]   incr_step;

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            incr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            start_l_q  <= '0;
            stop_l_q   <= '0;
            step_l_q   <= '0;
            dwell_l_q  <= '0;
            repeat_l_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            incr_q     <= incr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            start_l_q  <= start_l_d;
            stop_l_q   <= stop_l_d;
            step_l_q   <= step_l_d;
            dwell_l_q  <= dwell_l_d;
            repeat_l_q <= repeat_l_d;
        end
    end

    // Next increment toward stop, clamped so it never overshoots or wraps
    always_comb begin
        dir_up    = (stop_l_q >= start_l_q);
        sum_up    = {1'b0, incr_q} + {1'b0, step_l_q};
        dwell_end = (cnt_q == (dwell_l_q - DWELL_W'(1)));
        incr_step = stop_l_q;
        if (step_l_q == '0) begin
            incr_step = stop_l_q;
        end else if (dir_up) begin
            incr_step = (sum_up >= {1'b0, stop_l_q}) ? stop_l_q : sum_up[WIDTH-1:0];
        end else begin
            incr_step = ((incr_q < step_l_q) || ((incr_q - step_l_q) <= stop_l_q))
                        ? stop_l_q : (incr_q - step_l_q);
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        incr_d     = incr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        start_l_d  = start_l_q;
        stop_l_d   = stop_l_q;
        step_l_d   = step_l_q;
        dwell_l_d  = dwell_l_q;
        repeat_l_d = repeat_l_q;

        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    start_l_d  = sif.start_incr;
                    stop_l_d   = sif.stop_incr;
                    step_l_d   = sif.step;
                    dwell_l_d  = (sif.dwell == '0) ? DWELL_W'(1) : sif.dwell;
                    repeat_l_d = sif.repeat_mode;
                    incr_d     = sif.start_incr;
                    en_d       = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (sif.abort) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (dwell_end) begin
                    cnt_d = '0;
                    if (incr_q == stop_l_q) begin
                        done_d = 1'b1;
                        if (repeat_l_q) begin
                            incr_d = start_l_q;
                        end else begin
                            en_d    = 1'b0;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        incr_d = incr_step;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sif.en   = en_q;
    assign sif.incr = incr_q;
    assign sif.busy = busy_q;
    assign sif.done = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: stimulus queues expected output cycles,
// a negedge monitor pops and compares whenever en or done is high.
module tb_sweep_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sweep_ctrl_if #(.WIDTH(W), .DWELL_W(DW)) sif ();

    sweep_ctrl #(.WIDTH(W), .DWELL_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    typedef struct packed {
        logic         en;
        logic [W-1:0] incr;
        logic         busy;
        logic         done;
    } obs_t;

    obs_t  expq[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    string cur_test = "init";

    function automatic obs_t mk(input logic en, input logic [W-1:0] incr,
                                input logic busy, input logic done);
        obs_t o;
        o.en   = en;
        o.incr = incr;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    function automatic void check_obs(input string nm, input obs_t act, input obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got en=%b incr=%0d busy=%b done=%b, expected en=%b incr=%0d busy=%b done=%b",
                     nm, act.en, act.incr, act.busy, act.done, exp.en, exp.incr, exp.busy, exp.done);
        end
    endfunction

    function automatic obs_t sample();
        return mk(sif.en, sif.incr, sif.busy, sif.done);
    endfunction

    // Monitor: every cycle presenting en or done consumes one scoreboard entry
    always @(negedge clk) begin
        if (rst === 1'b1 && (sif.en === 1'b1 || sif.done === 1'b1)) begin
            obs_t a;
            a = sample();
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s unexpected output: en=%b incr=%0d busy=%b done=%b",
                         cur_test, a.en, a.incr, a.busy, a.done);
            end else begin
                check_obs(cur_test, a, expq.pop_front());
            end
        end
    end

    task automatic push_hold(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) expq.push_back(mk(1'b1, v, 1'b1, 1'b0));
    endtask

    task automatic push_done(input logic [W-1:0] v);
        expq.push_back(mk(1'b0, v, 1'b0, 1'b1));
    endtask

    task automatic cfg(input logic [W-1:0] s, input logic [W-1:0] p, input logic [W-1:0] st,
                       input logic [DW-1:0] d, input logic r);
        sif.start_incr  = s;
        sif.stop_incr   = p;
        sif.step        = st;
        sif.dwell       = d;
        sif.repeat_mode = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the sweep to end, then require the scoreboard to be drained
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sif.busy === 1'b0 && sif.done === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s timeout: busy=%b done=%b after 300 cycles, expected idle",
                     cur_test, sif.busy, sif.done);
        end
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover: %0d expected outputs not seen, expected 0",
                     cur_test, expq.size());
            expq.delete();
        end
    endtask

    task automatic run_simple();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b0;
        sif.start = 1'b0;
        sif.abort = 1'b0;
        cfg('0, '0, '0, '0, 1'b0);
        repeat (2) tick();
        cur_test = "reset";
        check_obs(cur_test, sample(), mk(1'b0, 8'd0, 1'b0, 1'b0));
        rst = 1'b1;
        tick();

        // Up sweep, start held high well into RUN
        cur_test = "up";
        cfg(8'd10, 8'd40, 8'd10, 16'd3, 1'b0);
        push_hold(8'd10, 3); push_hold(8'd20, 3); push_hold(8'd30, 3); push_hold(8'd40, 3);
        push_done(8'd40);
        sif.start = 1'b1;
        repeat (5) tick();
        sif.start = 1'b0;
        wait_idle();

        cur_test = "down";
        cfg(8'd200, 8'd190, 8'd4, 16'd1, 1'b0);
        push_hold(8'd200, 1); push_hold(8'd196, 1); push_hold(8'd192, 1); push_hold(8'd190, 1);
        push_done(8'd190);
        run_simple();

        cur_test = "overflow";
        cfg(8'd250, 8'd255, 8'd4, 16'd2, 1'b0);
        push_hold(8'd250, 2); push_hold(8'd254, 2); push_hold(8'd255, 2);
        push_done(8'd255);
        run_simple();

        cur_test = "dwell0";
        cfg(8'd1, 8'd3, 8'd1, 16'd0, 1'b0);
        push_hold(8'd1, 1); push_hold(8'd2, 1); push_hold(8'd3, 1);
        push_done(8'd3);
        run_simple();

        cur_test = "step0";
        cfg(8'd3, 8'd9, 8'd0, 16'd2, 1'b0);
        push_hold(8'd3, 2); push_hold(8'd9, 2);
        push_done(8'd9);
        run_simple();

        cur_test = "degenerate";
        cfg(8'd50, 8'd50, 8'd7, 16'd2, 1'b0);
        push_hold(8'd50, 2);
        push_done(8'd50);
        run_simple();

        // Back-to-back: start still high in the done cycle; config changed mid-run is ignored
        cur_test = "b2b";
        cfg(8'd1, 8'd2, 8'd1, 16'd1, 1'b0);
        push_hold(8'd1, 1); push_hold(8'd2, 1); push_done(8'd2);
        push_hold(8'd10, 1); push_hold(8'd12, 1); push_done(8'd12);
        sif.start = 1'b1;
        tick();
        cfg(8'd10, 8'd12, 8'd2, 16'd1, 1'b0);
        repeat (3) tick();
        sif.start = 1'b0;
        wait_idle();

        // Repeating sweep aborted while incr=6 on the second pass
        cur_test = "repeat";
        cfg(8'd5, 8'd7, 8'd1, 16'd1, 1'b1);
        push_hold(8'd5, 1); push_hold(8'd6, 1); push_hold(8'd7, 1);
        expq.push_back(mk(1'b1, 8'd5, 1'b1, 1'b1));
        push_hold(8'd6, 1);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        repeat (4) tick();
        sif.abort = 1'b1;
        tick();
        sif.abort = 1'b0;
        check_obs("abort", sample(), mk(1'b0, 8'd6, 1'b0, 1'b0));
        wait_idle();

        // Abort coincident with finish suppresses done
        cur_test = "abort_finish";
        cfg(8'd5, 8'd6, 8'd1, 16'd1, 1'b0);
        push_hold(8'd5, 1); push_hold(8'd6, 1);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        tick();
        sif.abort = 1'b1;
        tick();
        check_obs("abort_finish", sample(), mk(1'b0, 8'd6, 1'b0, 1'b0));
        tick();
        sif.abort = 1'b0;
        check_obs("abort_idle", sample(), mk(1'b0, 8'd6, 1'b0, 1'b0));
        wait_idle();

        // Reset mid-sweep, then a fresh sweep
        cur_test = "rst_mid";
        cfg(8'd10, 8'd100, 8'd1, 16'd4, 1'b0);
        push_hold(8'd10, 1);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_obs("rst_mid", sample(), mk(1'b0, 8'd0, 1'b0, 1'b0));
        wait_idle();

        cur_test = "after_rst";
        cfg(8'd20, 8'd22, 8'd2, 16'd1, 1'b0);
        push_hold(8'd20, 1); push_hold(8'd22, 1);
        push_done(8'd22);
        run_simple();

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached in %s", cur_test);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the en/incr inputs of the sine generator (counter + sine ROM) to produce linear chirps.
Steps the phase increment from a start value to a stop value in fixed-size steps. Each value is held for a programmable dwell time.
Single-shot or continuously repeating sweeps; sits between the top-level control inputs and sinegen.

Parameters:
WIDTH, 8, width of phase increment (matches sinegen WIDTH)
DWELL_W, 16, width of dwell-time field (cycles per increment value)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (asserted when 0)
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  terminate sweep; sampled only in RUN
repeat_mode  input  1  0 = single sweep, 1 = restart at start_incr after each sweep
start_incr  input  WIDTH  first increment value
stop_incr  input  WIDTH  final increment value
step  input  WIDTH  magnitude of increment change per dwell period
dwell  input  DWELL_W  cycles per increment value; 0 treated as 1
en  output  1  enable to sinegen counter
incr  output  WIDTH  increment to sinegen counter
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at end of each completed sweep

Behaviour:
- Reset (rst==0 at posedge) has priority over all inputs, including mid-sweep. It forces:
  - state IDLE
  - en=0, incr=0, busy=0, done=0
  - dwell counter=0
  - latched config=0
- Registered outputs: all outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, RUN.
- IDLE:
  - done=0 unless set by the finishing transition in the previous cycle.
  - start==1 at posedge T: latch start_incr, stop_incr, step, dwell (0->1), repeat_mode.
    - After T: incr=start_incr, en=1, busy=1, dwell_cnt=0, state RUN.
  - abort is ignored in IDLE. start and abort both high in IDLE: start wins.
- RUN:
  - Input changes to config ports are ignored; latched copies are used.
  - start is ignored.
  - dwell_cnt increments each cycle. Dwell end is dwell_cnt == dwell_l-1; dwell_cnt then returns to 0.
- Step rule at dwell end:
  - Direction is up if stop_l >= start_l, else down.
  - If incr == stop_l: sweep finished.
  - Else, up: next = incr+step_l computed in WIDTH+1 bits; if next >= stop_l (including carry-out) then incr=stop_l, else incr=next.
  - Else, down: if incr < step_l or incr-step_l <= stop_l then incr=stop_l, else incr=incr-step_l.
  - step_l==0: incr jumps to stop_l at the first dwell end (guarantees termination).
- Finish:
  - repeat_l==0: next cycle en=0, busy=0, done=1 for exactly one cycle, state IDLE. incr holds stop_l.
  - repeat_l==1: next cycle incr=start_l, done=1 for one cycle, en and busy stay 1, dwell_cnt=0, state stays RUN.
- Dwell hold: every incr value, including start and stop, is presented with en=1 for exactly dwell_l consecutive cycles.
- Degenerate sweep: start_l == stop_l gives one dwell period, then finish.
- Abort: abort==1 in RUN at posedge gives next cycle en=0, busy=0, done=0, state IDLE. incr holds its current value.
  - abort in the same cycle as a finish: abort wins; no done pulse.
- Back-to-back: start asserted in the cycle after a single-shot finish (IDLE, done high) begins a new sweep normally.

Test Plan:
- Up sweep: start=10, stop=40, step=10, dwell=3, repeat=0 -> incr 10,20,30,40, each held 3 cycles with en=1 (12 cycles total). Next cycle en=0, busy=0, done=1 for one cycle; incr stays 40.
- Down sweep with clamp: start=200, stop=190, step=4, dwell=1 -> incr 200,196,192,190, one cycle each, then done pulse.
- Overflow clamp: start=250, stop=255, step=4, dwell=2 -> incr 250,254,255 (no wrap to 2), each held 2 cycles, then done.
- Repeat and abort: start=5, stop=7, step=1, dwell=1, repeat=1 -> incr 5,6,7,5,6,7...; done pulses in the cycles where incr returns to 5. abort asserted while incr=6 -> next cycle en=0, busy=0, done=0, incr=6.
- Edge cases:
  - dwell=0 behaves as dwell=1.
  - step=0 with start=3, stop=9 -> incr 3 then 9, then done.
  - start held high during RUN has no effect.
- Reset mid-sweep: rst=0 for one posedge while busy -> next cycle en=0, incr=0, busy=0, done=0. Then start=1 begins a fresh sweep from the new start_incr.
